// File: rtl/decode_stage.sv
// decode_pkg: immediate-format encoding, decoded payload and RV32 immediate expanders.
// decode_stage: RV32 decode pipeline stage with a 1-entry skid buffer between fetch and execute.
//   clk, rst (sync, active-high), flush   : clock, reset, redirect discard
//   if_valid/if_ready/if_inst/if_pc       : fetch-side handshake and payload
//   id_valid/id_ready/id_pc/id_inst       : execute-side handshake and payload
//   id_imm/id_imm_type/id_illegal         : expanded immediate, its format, unsupported flag
//   id_rs1/id_rs2/id_rd                   : register fields of the held instruction
package decode_pkg;
    localparam int unsigned INST_WIDTH = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [INST_WIDTH-1:0] imm;
        imm_type_e             imm_type;
        logic                  illegal;
    } dec_t;

    function automatic logic [31:0] decode_i_immed(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] decode_s_immed(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] decode_b_immed(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] decode_u_immed(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] decode_j_immed(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // CSR immediate form: zimm in [16:12], csr address in [11:0]
    function automatic logic [31:0] decode_z_immed(input logic [31:0] inst);
        return {15'b0, inst[19:15], inst[31:20]};
    endfunction
endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_inst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [31:0]           id_inst,
    output logic [31:0]           id_imm,
    output logic [2:0]            id_imm_type,
    output logic [4:0]            id_rs1,
    output logic [4:0]            id_rs2,
    output logic [4:0]            id_rd,
    output logic                  id_illegal
);

    imm_type_e             imm_type_c;
    logic                  illegal_c;
    dec_t                  dec_c;
    logic                  accept_c;

    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_pc_q,    out_pc_d;
    dec_t                  out_dec_q,   out_dec_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q,    skid_pc_d;
    dec_t                  skid_dec_q,   skid_dec_d;

    // Opcode classification; inst[1:0] is part of the opcode, so non-11 encodings fall to default
    always_comb begin
        imm_type_c = IMM_NONE;
        illegal_c  = 1'b0;
        case (if_inst[6:0])
            7'b0110111, 7'b0010111:                         imm_type_c = IMM_U;
            7'b1101111:                                     imm_type_c = IMM_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: imm_type_c = IMM_I;
            7'b0100011:                                     imm_type_c = IMM_S;
            7'b1100011:                                     imm_type_c = IMM_B;
            7'b0110011:                                     imm_type_c = IMM_NONE;
            7'b1110011: imm_type_c = if_inst[14] ? IMM_Z : IMM_I;
            default:                                        illegal_c  = 1'b1;
        endcase
    end

    // Immediate expansion for the classified format
    always_comb begin
        dec_c          = '0;
        dec_c.inst     = if_inst;
        dec_c.imm_type = imm_type_c;
        dec_c.illegal  = illegal_c;
        case (imm_type_c)
            IMM_I:   dec_c.imm = decode_i_immed(if_inst);
            IMM_S:   dec_c.imm = decode_s_immed(if_inst);
            IMM_B:   dec_c.imm = decode_b_immed(if_inst);
            IMM_U:   dec_c.imm = decode_u_immed(if_inst);
            IMM_J:   dec_c.imm = decode_j_immed(if_inst);
            IMM_Z:   dec_c.imm = decode_z_immed(if_inst);
            default: dec_c.imm = 32'h0;
        endcase
    end

    // Ready depends only on skid occupancy, never on id_ready
    assign if_ready = !skid_valid_q && !flush && !rst;
    assign accept_c = if_valid && if_ready;

    // Out/skid next state: skid drains first so ordering stays FIFO
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_dec_d    = out_dec_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_dec_d   = skid_dec_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || id_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_dec_d    = skid_dec_q;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_valid_d = 1'b1;
                out_pc_d    = if_pc;
                out_dec_d   = dec_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = if_pc;
            skid_dec_d   = dec_c;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_dec_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_dec_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_dec_q    <= out_dec_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_dec_q   <= skid_dec_d;
        end
    end

    assign id_valid    = out_valid_q;
    assign id_pc       = out_pc_q;
    assign id_inst     = out_dec_q.inst;
    assign id_imm      = out_dec_q.imm;
    assign id_imm_type = out_dec_q.imm_type;
    assign id_illegal  = out_dec_q.illegal;
    assign id_rs1      = out_dec_q.inst[19:15];
    assign id_rs2      = out_dec_q.inst[24:20];
    assign id_rd       = out_dec_q.inst[11:7];

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed checks of the documented scenarios, then
// randomized traffic compared against a queue-based reference of the stage.
module tb_decode_stage;
    localparam int unsigned ADDR_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  if_valid = 1'b0;
    logic                  if_ready;
    logic [31:0]           if_inst = 32'h0;
    logic [ADDR_WIDTH-1:0] if_pc = '0;
    logic                  id_valid;
    logic                  id_ready = 1'b0;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [31:0]           id_inst;
    logic [31:0]           id_imm;
    logic [2:0]            id_imm_type;
    logic [4:0]            id_rs1, id_rs2, id_rd;
    logic                  id_illegal;

    decode_stage #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .id_imm(id_imm), .id_imm_type(id_imm_type), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        illegal;
    } exp_t;

    // Reference decode from the ISA rules, using shifts/masks on the whole word
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sx;
        logic [6:0]  opc;
        sx = 32'($signed(inst) >>> 20);
        opc = inst[6:0];
        e.pc = pc; e.inst = inst; e.illegal = 1'b0; e.typ = 3'd0;
        if (opc == 7'h37 || opc == 7'h17) e.typ = 3'd4;
        else if (opc == 7'h6F) e.typ = 3'd5;
        else if (opc == 7'h67 || opc == 7'h03 || opc == 7'h13 || opc == 7'h0F) e.typ = 3'd1;
        else if (opc == 7'h23) e.typ = 3'd2;
        else if (opc == 7'h63) e.typ = 3'd3;
        else if (opc == 7'h73) e.typ = inst[14] ? 3'd6 : 3'd1;
        else if (opc != 7'h33) e.illegal = 1'b1;
        case (e.typ)
            3'd1: e.imm = sx;
            3'd2: e.imm = (sx & ~32'h1F) | ((inst >> 7) & 32'h1F);
            3'd3: e.imm = (32'($signed(inst) >>> 19) & ~32'hFFF) | (((inst >> 7) & 1) << 11)
                        | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
            3'd4: e.imm = inst & 32'hFFFFF000;
            3'd5: e.imm = (32'($signed(inst) >>> 11) & ~32'hFFFFF) | (inst & 32'h000FF000)
                        | (((inst >> 20) & 1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
            3'd6: e.imm = (((inst >> 15) & 32'h1F) << 12) | (inst >> 20);
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    // Reference: queue of entries held in the stage (at most two)
    exp_t        q[$];
    logic        rst_seen = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_inst = 32'h0;

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_id_valid", 32'(id_valid), 32'h0);
            check("rst_id_pc", id_pc, 32'h0);
            check("rst_id_inst", id_inst, 32'h0);
            check("rst_id_imm", id_imm, 32'h0);
            check("rst_id_imm_type", 32'(id_imm_type), 32'h0);
            check("rst_id_illegal", 32'(id_illegal), 32'h0);
            check("rst_id_regs", {17'h0, id_rs1, id_rs2, id_rd}, 32'h0);
        end
        check("id_valid", 32'(id_valid), 32'(q.size() > 0));
        check("if_ready", 32'(if_ready), 32'(q.size() < 2 && !flush && !rst));
        if (id_valid && q.size() > 0) begin
            check("id_pc", id_pc, q[0].pc);
            check("id_inst", id_inst, q[0].inst);
            check("id_imm", id_imm, q[0].imm);
            check("id_imm_type", 32'(id_imm_type), 32'(q[0].typ));
            check("id_illegal", 32'(id_illegal), 32'(q[0].illegal));
            check("id_rs1", 32'(id_rs1), (q[0].inst >> 15) & 32'h1F);
            check("id_rs2", 32'(id_rs2), (q[0].inst >> 20) & 32'h1F);
            check("id_rd", 32'(id_rd), (q[0].inst >> 7) & 32'h1F);
        end
        if (stalled_prev) begin
            check("hold_pc", id_pc, prev_pc);
            check("hold_inst", id_inst, prev_inst);
        end
        // Transfers that the coming edge will perform
        if (rst || flush) begin
            q.delete();
        end else begin
            if (id_valid && id_ready && q.size() > 0) void'(q.pop_front());
            if (if_valid && if_ready) q.push_back(ref_decode(if_inst, if_pc));
        end
        stalled_prev = id_valid && !id_ready && !rst && !flush;
        prev_pc      = id_pc;
        prev_inst    = id_inst;
        rst_seen     = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
        step();
        if_valid = 1'b0;
    endtask

    logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                             7'h0F, 7'h23, 7'h63, 7'h33, 7'h73, 7'h73};

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        int          sel;

        repeat (2) step();
        rst = 1'b0;
        id_ready = 1'b1;

        // Immediate formats of the documented sample instructions
        send(32'hFFF00093, 32'h10);
        @(negedge clk);
        check("addi_imm", id_imm, 32'hFFFFFFFF);
        check("addi_type", 32'(id_imm_type), 32'd1);
        check("addi_rd", 32'(id_rd), 32'd1);
        check("addi_rs1", 32'(id_rs1), 32'd0);
        send(32'hFE112E23, 32'h14);
        @(negedge clk);
        check("sw_imm", id_imm, 32'hFFFFFFFC);
        check("sw_type", 32'(id_imm_type), 32'd2);
        check("sw_rs1", 32'(id_rs1), 32'd2);
        check("sw_rs2", 32'(id_rs2), 32'd1);
        send(32'h123452B7, 32'h18);
        @(negedge clk);
        check("lui_imm", id_imm, 32'h12345000);
        check("lui_type", 32'(id_imm_type), 32'd4);
        check("lui_rd", 32'(id_rd), 32'd5);
        send(32'h3002D073, 32'h1C);
        @(negedge clk);
        check("csrrwi_type", 32'(id_imm_type), 32'd6);
        check("csrrwi_imm", id_imm, 32'h00005300);
        send(32'h00000000, 32'h20);
        @(negedge clk);
        check("zero_illegal", 32'(id_illegal), 32'd1);
        check("zero_type", 32'(id_imm_type), 32'd0);
        check("zero_imm", id_imm, 32'h0);
        step();

        // Backpressure: two held, third waits, then drained in order
        id_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h00000013; if_pc = 32'h0;
        step();
        if_pc = 32'h4;
        step();
        if_pc = 32'h8;
        @(negedge clk);
        check("bp_if_ready_low", 32'(if_ready), 32'd0);
        check("bp_head_pc", id_pc, 32'h0);
        step();
        id_ready = 1'b1;
        @(negedge clk);
        check("drain_pc0", id_pc, 32'h0);
        step();
        @(negedge clk);
        check("drain_pc4", id_pc, 32'h4);
        step();
        if_valid = 1'b0;
        @(negedge clk);
        check("drain_pc8", id_pc, 32'h8);
        step();

        // Flush with the stage full
        id_ready = 1'b0;
        send(32'h00100093, 32'h100);
        send(32'h00200093, 32'h104);
        flush = 1'b1; if_valid = 1'b1; if_inst = 32'h00300093; if_pc = 32'h108;
        step();
        flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("flush_id_valid", 32'(id_valid), 32'd0);
        check("flush_if_ready", 32'(if_ready), 32'd1);
        step();
        @(negedge clk);
        check("flush_no_emit", 32'(id_valid), 32'd0);

        // Reset with the stage full, then 1-cycle latency after release
        send(32'h00100093, 32'h180);
        send(32'h00200093, 32'h184);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        rst = 1'b0;
        id_ready = 1'b1;
        step();
        send(32'hFFF00093, 32'h200);
        @(negedge clk);
        check("post_rst_valid", 32'(id_valid), 32'd1);
        check("post_rst_pc", id_pc, 32'h200);
        step();

        // Randomized traffic against the reference queue
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom;
            sel = int'($urandom_range(0, 12));
            opc = (sel < 12) ? ops[sel] : r[6:0];
            if_valid = ($urandom_range(0, 3) != 0);
            if_inst  = {r[31:7], opc};
            if_pc    = 32'(i * 4);
            id_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            step();
        end
        if_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
